spi_txn_sequencer: RTL and testbench

- Upstream command sequencer for the 3-slave SPI top.
- Buffers byte-transfer commands (data, slave, mode) in a small FIFO and drives the SPI top's min/slaveselct/mode/reset inputs through a load-then-shift sequence.
- Captures mout after a fixed number of shift clocks and returns it on a valid/ready response port.
- Replaces hand-sequenced bench stimulus with a reusable front end.

---
 rtl/spi_seq_pkg.sv | 20 ++
 rtl/spi_txn_sequencer_if.sv | 35 +++
 rtl/spi_cmd_fifo.sv | 45 ++++
 rtl/spi_txn_sequencer.sv | 167 ++++++++++++++++
 tb/tb_spi_txn_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types for the SPI transaction sequencer: FSM encoding and the
// layout of one queued byte-transfer command.
package spi_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] SLV_NONE = 2'b00;

    typedef struct packed {
        logic [1:0] mode;
        logic [1:0] slave;
        logic [7:0] data;
    } cmd_entry_t;

endpackage

// File: rtl/spi_txn_sequencer_if.sv
// Command, response and SPI-top signals of the sequencer. The slave modport
// is the sequencer's view; master is the surrounding system's view.
interface spi_txn_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [1:0] cmd_slave;
    logic [1:0] cmd_mode;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_slave;
    logic       rsp_err;

    logic [7:0] spi_min;
    logic [1:0] spi_slaveselct;
    logic [1:0] spi_mode;
    logic       spi_reset;
    logic [7:0] spi_mout;

    modport slave (
        input  cmd_valid, cmd_data, cmd_slave, cmd_mode, rsp_ready, spi_mout,
        output cmd_ready, rsp_valid, rsp_data, rsp_slave, rsp_err,
               spi_min, spi_slaveselct, spi_mode, spi_reset
    );

    modport master (
        output cmd_valid, cmd_data, cmd_slave, cmd_mode, rsp_ready, spi_mout,
        input  cmd_ready, rsp_valid, rsp_data, rsp_slave, rsp_err,
               spi_min, spi_slaveselct, spi_mode, spi_reset
    );

endinterface

// File: rtl/spi_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate occupancy counter.
module spi_cmd_fifo
    import spi_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  cmd_entry_t wdata_i,
    input  logic       pop_i,
    output cmd_entry_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    cmd_entry_t  mem_q [DEPTH];

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    // NOTE: non-blocking assignments in clocked logic so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/spi_txn_sequencer.sv
// Front end for the 3-slave SPI top: pops queued commands, runs a
// load-then-shift sequence on the SPI inputs and returns the captured byte.
module spi_txn_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int LOAD_CYCLES = 2,
    parameter int XFER_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    spi_txn_sequencer_if.slave        bus,
    output logic                      busy,
    output logic [7:0]                xfer_count
);

    localparam int CNT_MAX = (LOAD_CYCLES > XFER_CYCLES) ? LOAD_CYCLES : XFER_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(XFER_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       spi_min_q, spi_min_d;
    logic [1:0]       spi_sel_q, spi_sel_d;
    logic [1:0]       spi_mode_q, spi_mode_d;
    logic             spi_reset_q, spi_reset_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_slave_q, rsp_slave_d;
    logic             rsp_err_q, rsp_err_d;
    logic [7:0]       xfer_count_q, xfer_count_d;

    cmd_entry_t push_entry;
    cmd_entry_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;

    assign push_entry = '{mode: bus.cmd_mode, slave: bus.cmd_slave, data: bus.cmd_data};
    assign push       = bus.cmd_valid && bus.cmd_ready;

    spi_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        spi_min_d    = spi_min_q;
        spi_sel_d    = spi_sel_q;
        spi_mode_d   = spi_mode_q;
        spi_reset_d  = spi_reset_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_slave_d  = rsp_slave_q;
        rsp_err_d    = rsp_err_q;
        xfer_count_d = xfer_count_q;
        pop          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                spi_reset_d = 1'b1;
                if (!fifo_empty) begin
                    pop = 1'b1;
                    // An illegal slave completes immediately without touching the bus.
                    if (head.slave == SLV_NONE) begin
                        state_d     = ST_DONE;
                        cnt_d       = '0;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 8'h00;
                        rsp_slave_d = SLV_NONE;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d    = ST_LOAD;
                        cnt_d      = LOAD_LAST;
                        spi_min_d  = head.data;
                        spi_sel_d  = head.slave;
                        spi_mode_d = head.mode;
                    end
                end
            end
            ST_LOAD: begin
                if (cnt_q == '0) begin
                    state_d     = ST_SHIFT;
                    cnt_d       = XFER_LAST;
                    spi_reset_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d      = ST_DONE;
                    cnt_d        = '0;
                    spi_reset_d  = 1'b1;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = bus.spi_mout;
                    rsp_slave_d  = spi_sel_q;
                    rsp_err_d    = 1'b0;
                    xfer_count_d = xfer_count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b0;
                    spi_sel_d   = SLV_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            spi_min_q    <= 8'h00;
            spi_sel_q    <= SLV_NONE;
            spi_mode_q   <= 2'b00;
            spi_reset_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 8'h00;
            rsp_slave_q  <= 2'b00;
            rsp_err_q    <= 1'b0;
            xfer_count_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            spi_min_q    <= spi_min_d;
            spi_sel_q    <= spi_sel_d;
            spi_mode_q   <= spi_mode_d;
            spi_reset_q  <= spi_reset_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_slave_q  <= rsp_slave_d;
            rsp_err_q    <= rsp_err_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign bus.cmd_ready      = !fifo_full;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_slave      = rsp_slave_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.spi_min        = spi_min_q;
    assign bus.spi_slaveselct = spi_sel_q;
    assign bus.spi_mode       = spi_mode_q;
    assign bus.spi_reset      = spi_reset_q;
    assign busy               = (state_q != ST_IDLE) || !fifo_empty;
    assign xfer_count         = xfer_count_q;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer with a behavioural SPI top that returns
// the inverted min byte only once a full byte time has elapsed.
module tb_spi_txn_sequencer;

    localparam int LOAD_CYCLES = 2;
    localparam int XFER_CYCLES = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [7:0] xfer_count;

    spi_txn_sequencer_if bus();

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int low_cnt     = 0;
    int last_pulse  = 0;
    int pulse_cnt   = 0;
    logic [1:0] sel_low  = 2'b00;
    logic [7:0] min_low  = 8'h00;
    logic [1:0] mode_low = 2'b00;

    always #5 clk = ~clk;

    spi_txn_sequencer #(
        .DEPTH       (4),
        .LOAD_CYCLES (LOAD_CYCLES),
        .XFER_CYCLES (XFER_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    // mout is meaningful only at the end of the eighth shift clock.
    assign bus.spi_mout = (!bus.spi_reset && low_cnt == XFER_CYCLES - 1) ? ~bus.spi_min : 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!bus.spi_reset) begin
            low_cnt  <= low_cnt + 1;
            sel_low  <= bus.spi_slaveselct;
            min_low  <= bus.spi_min;
            mode_low <= bus.spi_mode;
        end else begin
            if (low_cnt != 0) begin
                last_pulse <= low_cnt;
                pulse_cnt  <= pulse_cnt + 1;
            end
            low_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] s, input logic [1:0] m);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        bus.cmd_slave = s;
        bus.cmd_mode  = m;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Returns the number of edges until rsp_valid is seen, or -1 on timeout.
    task automatic wait_rsp(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.rsp_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n, e0, prev, acc, pc0, pushed, got, x255;
        bit stable, quiet;
        logic [7:0] b2b_d   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [1:0] b2b_s   [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
        logic [7:0] b2b_r   [4] = '{8'hEE, 8'hDD, 8'hCC, 8'hBB};
        logic [1:0] full_s  [6] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
        logic [7:0] full_r  [5] = '{8'h5F, 8'h5E, 8'h5D, 8'h5C, 8'h5B};

        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.cmd_slave = 2'b00;
        bus.cmd_mode  = 2'b00;
        bus.rsp_ready = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_fields", {bus.rsp_data, bus.rsp_slave, bus.rsp_err}, 0);
        check("rst_spi_bus", {bus.spi_min, bus.spi_slaveselct, bus.spi_mode}, 0);
        check("rst_spi_reset", bus.spi_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_xfer_count", xfer_count, 0);
        reset = 1'b1;
        repeat (2) tick();

        // Single transfer
        push(8'h55, 2'b01, 2'b11);
        check("single_busy", busy, 1);
        wait_rsp(40, n);
        check("single_latency", n, 1 + LOAD_CYCLES + XFER_CYCLES);
        check("single_data", bus.rsp_data, 8'hAA);
        check("single_slave", bus.rsp_slave, 2'b01);
        check("single_err", bus.rsp_err, 0);
        check("single_count", xfer_count, 1);
        tick();
        check("single_pulse", last_pulse, XFER_CYCLES);
        check("single_bus_latched", {min_low, sel_low, mode_low}, {8'h55, 2'b01, 2'b11});
        check("single_hold", bus.rsp_valid, 1);
        bus.rsp_ready = 1'b1;
        tick();
        check("single_release", bus.rsp_valid, 0);
        check("single_sel_idle", bus.spi_slaveselct, 2'b00);
        tick();

        // Back-to-back across all three slaves
        e0 = 0;
        for (int k = 0; k < 4; k++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_data  = b2b_d[k];
            bus.cmd_slave = b2b_s[k];
            bus.cmd_mode  = 2'(k);
            tick();
            if (k == 0) e0 = cyc;
        end
        bus.cmd_valid = 1'b0;
        prev = e0;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(40, n);
            check($sformatf("b2b%0d_found", k), (n > 0), 1);
            check($sformatf("b2b%0d_spacing", k), cyc - prev, (k == 0) ? 11 : 12);
            check($sformatf("b2b%0d_data", k), bus.rsp_data, b2b_r[k]);
            check($sformatf("b2b%0d_slave", k), bus.rsp_slave, b2b_s[k]);
            check($sformatf("b2b%0d_sel", k), sel_low, b2b_s[k]);
            prev = cyc;
        end
        repeat (2) tick();
        check("b2b_count", xfer_count, 5);
        check("b2b_idle", busy, 0);

        // FIFO full under response backpressure
        bus.rsp_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_data  = 8'hA0 + 8'(k);
            bus.cmd_slave = full_s[k];
            bus.cmd_mode  = 2'b00;
            if (bus.cmd_ready) acc++;
            tick();
        end
        bus.cmd_valid = 1'b0;
        check("full_accepted", acc, 5);
        check("full_ready_low", bus.cmd_ready, 0);
        wait_rsp(40, n);
        check("full_first_data", bus.rsp_data, full_r[0]);
        stable = 1'b1;
        repeat (6) begin
            tick();
            if (!(bus.rsp_valid === 1'b1 && bus.rsp_data === full_r[0])) stable = 1'b0;
        end
        check("full_rsp_stable", stable, 1);
        check("full_no_new_start", bus.spi_reset, 1);
        check("full_still_full", bus.cmd_ready, 0);
        bus.rsp_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            wait_rsp(40, n);
            check($sformatf("full%0d_data", k), bus.rsp_data, full_r[k]);
            check($sformatf("full%0d_slave", k), bus.rsp_slave, full_s[k]);
        end
        repeat (2) tick();
        check("full_count", xfer_count, 10);
        check("full_drained", bus.cmd_ready, 1);

        // Illegal slave
        bus.rsp_ready = 1'b0;
        pc0 = pulse_cnt;
        push(8'h77, 2'b00, 2'b10);
        wait_rsp(40, n);
        check("illegal_latency", n, 1);
        check("illegal_err", bus.rsp_err, 1);
        check("illegal_data", bus.rsp_data, 8'h00);
        check("illegal_sel", bus.spi_slaveselct, 2'b00);
        repeat (3) tick();
        bus.rsp_ready = 1'b1;
        repeat (3) tick();
        check("illegal_no_pulse", pulse_cnt, pc0);
        check("illegal_count", xfer_count, 10);

        // Reset during SHIFT with a second command still queued
        bus.rsp_ready = 1'b0;
        push(8'h3C, 2'b01, 2'b00);
        push(8'hC3, 2'b10, 2'b00);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            if (bus.spi_reset === 1'b0) begin
                n = i;
                break;
            end
            tick();
        end
        check("rst_shift_entered", (n > 0), 1);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_mid_spi_reset", bus.spi_reset, 1);
        check("rst_mid_rsp_valid", bus.rsp_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_cmd_ready", bus.cmd_ready, 1);
        check("rst_mid_count", xfer_count, 0);
        reset = 1'b1;
        quiet = 1'b1;
        repeat (30) begin
            tick();
            if (bus.rsp_valid !== 1'b0 || bus.spi_reset !== 1'b1) quiet = 1'b0;
        end
        check("rst_mid_abandoned", quiet, 1);

        // Counter wrap after 256 legal transfers
        bus.rsp_ready = 1'b1;
        pushed = 0;
        got    = 0;
        x255   = -1;
        for (int i = 0; i < 5000 && got < 256; i++) begin
            bus.cmd_valid = (pushed < 256);
            bus.cmd_data  = 8'(i);
            bus.cmd_slave = 2'b11;
            bus.cmd_mode  = 2'b01;
            if (bus.cmd_valid && bus.cmd_ready) pushed++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                got++;
                if (got == 255) x255 = int'(xfer_count);
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
        check("wrap_responses", got, 256);
        check("wrap_at_255", x255, 255);
        check("wrap_count_zero", xfer_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
